result_forward_pipe: RTL
========================

RESULT_FORWARD_PIPE -- requirements
Module: result_forward_pipe

Interface
REQ-001 Parameter NUM_PIPES, default 2, number of issue pipes; pipe 0 = even, pipe 1 = odd; a higher index is later in program order.
REQ-002 Parameter DEPTH, default 7, number of result stages per pipe; stage DEPTH is writeback.
REQ-003 Parameter DATA_W, default 128, register data width.
REQ-004 Parameter ADDR_W, default 7, register address width.
REQ-005 Parameter NUM_SRC, default 3, source operands per pipe (ra, rb, rc).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  asynchronous active-low reset.
REQ-009 iss_valid  input  NUM_PIPES  per pipe, an instruction enters stage 1 at the next edge.
REQ-010 iss_reg_wr  input  NUM_PIPES  per pipe, the instruction writes a register.
REQ-011 iss_reg_dst  input  NUM_PIPES*ADDR_W  per-pipe destination address.
REQ-012 res_valid  input  NUM_PIPES  per pipe, a result is supplied this cycle.
REQ-013 res_stage  input  NUM_PIPES*4  per pipe, stage index (1..DEPTH-1) of the entry that receives the result.
REQ-014 res_data  input  NUM_PIPES*DATA_W  per-pipe result value.
REQ-015 flush  input  1  kills young entries (branch redirect from the odd pipe).
REQ-016 src_addr  input  NUM_PIPES*NUM_SRC*ADDR_W  operand addresses to look up.
REQ-017 fwd_hit  output  NUM_PIPES*NUM_SRC  the operand is supplied by forwarding.
REQ-018 fwd_data  output  NUM_PIPES*NUM_SRC*DATA_W  forwarded value; zero when fwd_hit=0.
REQ-019 hazard_stall  output  1  an operand matches an in-flight producer whose result is not ready.
REQ-020 wb_en, wb_addr, wb_data  output  NUM_PIPES, NUM_PIPES*ADDR_W, NUM_PIPES*DATA_W  registered writeback port per pipe.

Function
REQ-021 Each pipe SHALL hold DEPTH entry registers {valid, reg_wr, dst, ready, data}; every clock, entry s moves to s+1, and stage 1 loads the issue inputs with ready=0 and data=0.
REQ-022 A result with res_valid=1 and res_stage=s SHALL be written into the entry as it moves to s+1, setting ready=1; the write applies only if that entry is valid.
REQ-023 A res_stage of 0 or >= DEPTH SHALL be ignored (no state change).
REQ-024 wb_en[p] SHALL equal valid & reg_wr & ready of stage DEPTH of pipe p; wb_addr and wb_data SHALL mirror that entry; wb_en SHALL be 0 for an entry that is valid & reg_wr but not ready.
REQ-025 Forwarding is combinational: for each operand, the candidates are valid & reg_wr entries with dst == src_addr, across all pipes and stages 1..DEPTH.
REQ-026 Priority SHALL be lowest stage index first (youngest); within the same stage, the highest pipe index wins.
REQ-027 If the winning candidate is ready, fwd_hit=1 and fwd_data=its data; if it is not ready, fwd_hit=0 and hazard_stall=1. Older ready matches SHALL NOT be used past a younger unready one.
REQ-028 hazard_stall SHALL be the OR over all operands whose winner is unready; the block itself SHALL NOT hold state on a stall (the issue stage gates iss_valid).
REQ-029 flush=1 SHALL clear valid in stage 1 of all pipes and drop the same-edge issue; stages 2..DEPTH are unaffected.
REQ-030 Simultaneous flush and res_valid targeting stage 1 SHALL leave the entry invalid.
REQ-031 Two pipes writing back the same address in the same cycle SHALL both assert wb_en; the register file resolves the write in favour of the higher pipe.

Reset
REQ-032 While rst=0, all entry valid/ready bits SHALL clear asynchronously and all data/dst SHALL be zero, so that wb_en=0, fwd_hit=0 and hazard_stall=0.
REQ-033 The first issue SHALL be accepted on the first rising edge after rst deasserts; entries present when reset asserts mid-operation SHALL be lost without writeback.

Verification
REQ-034 Issue pipe0 dst=5 (reg_wr), result 0xAA at stage 2 -> wb_en[0]=1, wb_addr=5, wb_data=0xAA exactly DEPTH=7 cycles after issue.
REQ-035 Pipe0 dst=9 not yet ready, lookup src=9 -> hazard_stall=1, fwd_hit=0; after a result at stage 3 -> fwd_hit=1 and fwd_data equals the result.
REQ-036 Same stage, pipe0 and pipe1 both dst=12 and ready with 0x1/0x2 -> fwd_data=0x2; if pipe0 dst=12 is in stage 2 and pipe1 in stage 4 -> fwd_data=0x1.
REQ-037 Flush on the same cycle as an issue with dst=3, with a stage-3 entry dst=4 -> no writeback for 3, writeback for 4 proceeds.
REQ-038 Reset asserted mid-stream with 4 valid entries -> outputs zero immediately (no clock needed), and no writeback after release.
REQ-039 res_stage=0 and res_stage=7 inputs -> no entry changes and ready stays 0.

Source files
------------

// File: rtl/result_forward_pipe.sv
// Per-pipe result shift pipeline with youngest-first operand forwarding,
// hazard detection and a writeback port taken from the last stage.
module result_forward_pipe #(
    parameter int NUM_PIPES = 2,
    parameter int DEPTH     = 7,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int NUM_SRC   = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PIPES-1:0]                iss_valid,
    input  logic [NUM_PIPES-1:0]                iss_reg_wr,
    input  logic [NUM_PIPES*ADDR_W-1:0]         iss_reg_dst,
    input  logic [NUM_PIPES-1:0]                res_valid,
    input  logic [NUM_PIPES*4-1:0]              res_stage,
    input  logic [NUM_PIPES*DATA_W-1:0]         res_data,
    input  logic                                flush,
    input  logic [NUM_PIPES*NUM_SRC*ADDR_W-1:0] src_addr,
    output logic [NUM_PIPES*NUM_SRC-1:0]        fwd_hit,
    output logic [NUM_PIPES*NUM_SRC*DATA_W-1:0] fwd_data,
    output logic                                hazard_stall,
    output logic [NUM_PIPES-1:0]                wb_en,
    output logic [NUM_PIPES*ADDR_W-1:0]         wb_addr,
    output logic [NUM_PIPES*DATA_W-1:0]         wb_data
);

    // No backpressure: the issue stage is expected to gate iss_valid with
    // hazard_stall; an asserted iss_valid always enters stage 1 next edge.
    logic              e_valid  [NUM_PIPES][1:DEPTH];
    logic              e_reg_wr [NUM_PIPES][1:DEPTH];
    logic [ADDR_W-1:0] e_dst    [NUM_PIPES][1:DEPTH];
    logic              e_ready  [NUM_PIPES][1:DEPTH];
    logic [DATA_W-1:0] e_data   [NUM_PIPES][1:DEPTH];
    logic              res_hit  [NUM_PIPES][1:DEPTH];

    // Out-of-range stage indices never match, so they leave state untouched.
    always_comb begin
        for (int p = 0; p < NUM_PIPES; p++) begin
            for (int s = 1; s <= DEPTH; s++) begin
                res_hit[p][s] = res_valid[p] && (s < DEPTH) &&
                                (res_stage[p*4 +: 4] == 4'(s)) && e_valid[p][s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                for (int s = 1; s <= DEPTH; s++) begin
                    e_valid[p][s]  <= 1'b0;
                    e_reg_wr[p][s] <= 1'b0;
                    e_dst[p][s]    <= '0;
                    e_ready[p][s]  <= 1'b0;
                    e_data[p][s]   <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                e_valid[p][1]  <= iss_valid[p] & ~flush;
                e_reg_wr[p][1] <= iss_reg_wr[p];
                e_dst[p][1]    <= iss_reg_dst[p*ADDR_W +: ADDR_W];
                e_ready[p][1]  <= 1'b0;
                e_data[p][1]   <= '0;
                for (int s = 1; s < DEPTH; s++) begin
                    // flush kills the stage-1 entry as it advances, even if a result lands on it
                    e_valid[p][s+1]  <= e_valid[p][s] & ~(flush & (s == 1));
                    e_reg_wr[p][s+1] <= e_reg_wr[p][s];
                    e_dst[p][s+1]    <= e_dst[p][s];
                    e_ready[p][s+1]  <= e_ready[p][s] | res_hit[p][s];
                    e_data[p][s+1]   <= res_hit[p][s] ? res_data[p*DATA_W +: DATA_W]
                                                      : e_data[p][s];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PIPES; p++) begin
            wb_en[p]                      = e_valid[p][DEPTH] & e_reg_wr[p][DEPTH] &
                                            e_ready[p][DEPTH];
            wb_addr[p*ADDR_W +: ADDR_W]   = e_dst[p][DEPTH];
            wb_data[p*DATA_W +: DATA_W]   = e_data[p][DEPTH];
        end
    end

    // Scan oldest to youngest so the last match (lowest stage, highest pipe) wins.
    always_comb begin
        logic              found;
        logic              rdy;
        logic [DATA_W-1:0] dat;
        fwd_hit      = '0;
        fwd_data     = '0;
        hazard_stall = 1'b0;
        found        = 1'b0;
        rdy          = 1'b0;
        dat          = '0;
        for (int q = 0; q < NUM_PIPES; q++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                found = 1'b0;
                rdy   = 1'b0;
                dat   = '0;
                for (int s = DEPTH; s >= 1; s--) begin
                    for (int p = 0; p < NUM_PIPES; p++) begin
                        if (e_valid[p][s] && e_reg_wr[p][s] &&
                            e_dst[p][s] == src_addr[(q*NUM_SRC+k)*ADDR_W +: ADDR_W]) begin
                            found = 1'b1;
                            rdy   = e_ready[p][s];
                            dat   = e_data[p][s];
                        end
                    end
                end
                fwd_hit[q*NUM_SRC+k]                    = found & rdy;
                fwd_data[(q*NUM_SRC+k)*DATA_W +: DATA_W] = (found && rdy) ? dat : '0;
                hazard_stall                            = hazard_stall | (found & ~rdy);
            end
        end
    end

endmodule
